// File: rtl/arb8_pkg.sv
// Shared types and constants for the 8-way arbiter.
package arb8_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/arb8_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arb8_ctrl_if;
    import arb8_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             expired;
    logic             none;

    modport master (output req, done, input gnt, gnt_id, busy, expired, none);
    modport slave  (input req, done, output gnt, gnt_id, busy, expired, none);
endinterface

// File: rtl/arb8_ctrl_prio_enc8.sv
// 8-to-3 priority encoder; the highest set index wins, none flags an empty input.
module prio_enc8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    output logic [ID_W-1:0]  o_id,
    output logic             o_none
);
    always_comb begin
        o_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_req[i]) o_id = ID_W'(i);
        end
    end

    assign o_none = (i_req == '0);
endmodule

// File: rtl/arb8_ctrl.sv
// Single-owner 8-way arbiter with hold timeout.
// Define ARB8_RR_EN for round-robin arbitration; fixed priority (bit 7 highest) otherwise.
module arb8_ctrl
    import arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    arb8_ctrl_if.slave  bus
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       r_state, w_state_n;
    logic [N_REQ-1:0] r_gnt, w_gnt_n;
    logic [ID_W-1:0]  r_gnt_id, w_id_n;
    logic             r_busy, w_busy_n;
    logic             r_expired, w_exp_n;
    logic [7:0]       r_hold_cnt, w_cnt_n;

    logic [N_REQ-1:0] w_enc_in;
    logic [ID_W-1:0]  w_enc_id, w_win;
    logic             w_none, w_drop, w_to;

`ifdef ARB8_RR_EN
    logic [ID_W-1:0] r_last_id;

    // Rotate so the index just below the last winner lands on bit 7,
    // then add the offset back to recover the real index.
    always_comb begin
        w_enc_in = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_enc_in[j] = bus.req[ID_W'(j) + r_last_id];
        end
    end
    assign w_win = w_enc_id + r_last_id;

    always_ff @(posedge clk) begin
        if (reset)
            r_last_id <= '0;
        else if (r_state == IDLE && !w_none)
            r_last_id <= w_win;
    end
`else
    assign w_enc_in = bus.req;
    assign w_win    = w_enc_id;
`endif

    prio_enc8 u_enc (
        .i_req  (w_enc_in),
        .o_id   (w_enc_id),
        .o_none (w_none)
    );

    assign w_drop = !bus.req[r_gnt_id];
    assign w_to   = (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_state_n = r_state;
        w_gnt_n   = r_gnt;
        w_id_n    = r_gnt_id;
        w_busy_n  = r_busy;
        w_exp_n   = 1'b0;
        w_cnt_n   = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (!w_none) begin
                    w_state_n = GRANT;
                    w_gnt_n   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                    w_id_n    = w_win;
                    w_busy_n  = 1'b1;
                    w_cnt_n   = '0;
                end
            end
            GRANT: begin
                if (bus.done || w_drop || w_to) begin
                    w_state_n = IDLE;
                    w_gnt_n   = '0;
                    w_id_n    = '0;
                    w_busy_n  = 1'b0;
                    // Timeout is only flagged when nothing else caused the release.
                    w_exp_n   = w_to && !bus.done && !w_drop;
                end else if (r_hold_cnt != 8'hFF) begin
                    w_cnt_n = r_hold_cnt + 8'd1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_expired  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_gnt      <= w_gnt_n;
            r_gnt_id   <= w_id_n;
            r_busy     <= w_busy_n;
            r_expired  <= w_exp_n;
            r_hold_cnt <= w_cnt_n;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.busy    = r_busy;
    assign bus.expired = r_expired;
    assign bus.none    = w_none;
endmodule

// File: tb/tb_arb8_ctrl.sv
// Directed bench for arb8_ctrl (MAX_HOLD=4); expectations follow ARB8_RR_EN.
module tb_arb8_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    arb8_ctrl_if bus ();

    arb8_ctrl #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req  = 8'h00;
        bus.done = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL rst_gnt got %h want 00", bus.gnt); end
        checks++; if (bus.gnt_id !== 3'd0) begin errors++; $display("FAIL rst_id got %0d want 0", bus.gnt_id); end
        checks++; if (bus.busy !== 1'b0 || bus.expired !== 1'b0) begin errors++; $display("FAIL rst_busy_exp got %b%b want 00", bus.busy, bus.expired); end
        checks++; if (bus.none !== 1'b1) begin errors++; $display("FAIL rst_none got %b want 1", bus.none); end
        bus.req = 8'h24;
        #1;
        checks++; if (bus.none !== 1'b0) begin errors++; $display("FAIL rst_none_track got %b want 0", bus.none); end
        tick();
        checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL rst_hold_gnt got %h want 00", bus.gnt); end
        bus.req = 8'h00;
        reset   = 1'b0;
        tick();
    endtask

    task automatic test_basic_grant();
        logic [2:0] exp_id2;
`ifdef ARB8_RR_EN
        exp_id2 = 3'd2;
`else
        exp_id2 = 3'd5;
`endif
        bus.req = 8'b0010_0100;
        tick();
        checks++; if (bus.gnt !== 8'b0010_0000 || bus.gnt_id !== 3'd5) begin errors++; $display("FAIL basic_gnt got %h/%0d want 20/5", bus.gnt, bus.gnt_id); end
        checks++; if (bus.busy !== 1'b1 || bus.none !== 1'b0) begin errors++; $display("FAIL basic_busy got %b none %b want 1/0", bus.busy, bus.none); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.expired !== 1'b0) begin errors++; $display("FAIL done_rel got %h b%b e%b want 00 0 0", bus.gnt, bus.busy, bus.expired); end
        tick();
        checks++; if (bus.gnt_id !== exp_id2 || bus.busy !== 1'b1) begin errors++; $display("FAIL regrant got %0d b%b want %0d 1", bus.gnt_id, bus.busy, exp_id2); end
        bus.req = 8'h00;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.expired !== 1'b0) begin errors++; $display("FAIL drop_rel got %h e%b want 00 0", bus.gnt, bus.expired); end
        tick();
    endtask

    task automatic test_timeout();
        bus.req = 8'h01;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.gnt !== 8'h01 || bus.expired !== 1'b0) begin errors++; $display("FAIL hold_c%0d got %h e%b want 01 0", c, bus.gnt, bus.expired); end
            if (c < 3) tick();
        end
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.expired !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL expire got %h e%b b%b want 00 1 0", bus.gnt, bus.expired, bus.busy); end
        tick();
        checks++; if (bus.gnt !== 8'h01 || bus.expired !== 1'b0) begin errors++; $display("FAIL exp_regrant got %h e%b want 01 0", bus.gnt, bus.expired); end
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        checks++; if (bus.gnt !== 8'h00 || bus.expired !== 1'b0) begin errors++; $display("FAIL to_with_done got %h e%b want 00 0", bus.gnt, bus.expired); end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_no_switch();
        bus.req = 8'h04;
        tick();
        checks++; if (bus.gnt_id !== 3'd2) begin errors++; $display("FAIL ns_first got %0d want 2", bus.gnt_id); end
        bus.req = 8'h84;
        tick();
        checks++; if (bus.gnt !== 8'h04 || bus.gnt_id !== 3'd2) begin errors++; $display("FAIL ns_keep got %h/%0d want 04/2", bus.gnt, bus.gnt_id); end
        bus.req = 8'h80;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL ns_rel got %h b%b want 00 0", bus.gnt, bus.busy); end
        tick();
        checks++; if (bus.gnt !== 8'h80 || bus.gnt_id !== 3'd7) begin errors++; $display("FAIL ns_next got %h/%0d want 80/7", bus.gnt, bus.gnt_id); end
        bus.done = 1'b1;
        bus.req  = 8'h00;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.expired !== 1'b0) begin errors++; $display("FAIL both_rel got %h e%b want 00 0", bus.gnt, bus.expired); end
        tick();
        bus.done = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin errors++; $display("FAIL both_idle got %h b%b want 00 0", bus.gnt, bus.busy); end
    endtask

    task automatic test_reset_in_grant();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.req = 8'h08;
        tick();
        checks++; if (bus.gnt_id !== 3'd3 || bus.busy !== 1'b1) begin errors++; $display("FAIL rg_own got %0d b%b want 3 1", bus.gnt_id, bus.busy); end
        reset = 1'b1;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.expired !== 1'b0) begin errors++; $display("FAIL rg_rst got %h b%b e%b want 00 0 0", bus.gnt, bus.busy, bus.expired); end
        reset   = 1'b0;
        bus.req = 8'hFF;
        tick();
        checks++; if (bus.gnt_id !== 3'd7 || bus.gnt !== 8'h80) begin errors++; $display("FAIL rg_first got %h/%0d want 80/7", bus.gnt, bus.gnt_id); end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_seq [9];
`ifdef ARB8_RR_EN
        exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            checks++; if (bus.gnt_id !== exp_seq[g] || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_g%0d got %0d b%b want %0d 1", g, bus.gnt_id, bus.busy, exp_seq[g]); end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got %h b%b want 00 0", g, bus.gnt, bus.busy); end
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_done_idle();
        bus.req  = 8'h00;
        bus.done = 1'b1;
        tick();
        tick();
        bus.done = 1'b0;
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.expired !== 1'b0) begin errors++; $display("FAIL idle_done got %h b%b e%b want 00 0 0", bus.gnt, bus.busy, bus.expired); end
        checks++; if (bus.none !== 1'b1) begin errors++; $display("FAIL idle_none got %b want 1", bus.none); end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_timeout();
        test_no_switch();
        test_reset_in_grant();
        test_back_to_back();
        test_done_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb8_ctrl.md
ARB8_CTRL -- requirements
Module: arb8_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive grant cycles before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases resource this cycle.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when idle.
REQ-007 gnt_id  output  3  registered binary index of granted requester; 0 when idle.
REQ-008 busy  output  1  registered; 1 while in GRANT state.
REQ-009 expired  output  1  registered one-cycle pulse on forced release by hold timeout.
REQ-010 none  output  1  combinational; 1 when req == 8'h00.

Function
REQ-011 FSM SHALL have two states: IDLE and GRANT.
- IDLE: if req != 0 at an edge, the winner is loaded into gnt/gnt_id, busy=1, state -> GRANT, hold_cnt=0; otherwise stay in IDLE.
REQ-012 Grant latency SHALL be one cycle: request sampled at edge k, gnt visible after edge k.
REQ-013 In GRANT, release SHALL occur at the edge where any of the following is true:
- done=1
- req[gnt_id]=0
- hold_cnt == MAX_HOLD-1
On release: gnt=0, gnt_id=0, busy=0, state -> IDLE.
REQ-014 Otherwise, in GRANT, hold_cnt SHALL increment by 1 per cycle; hold_cnt is 8 bits and never wraps.
REQ-015 The grant SHALL never change owner while in GRANT; other requests are ignored until release.
REQ-016 At least one IDLE cycle (turnaround) SHALL separate consecutive grants, including to the same requester.
REQ-017 expired SHALL pulse for exactly one cycle, coincident with the release edge, only when the timeout is the sole release cause; if done or req drop coincides with the timeout, expired stays 0.
REQ-018 Simultaneous done and req[gnt_id] drop SHALL produce a single release.
REQ-019 done asserted in IDLE SHALL be ignored.
REQ-020 Fixed-priority winner SHALL be the highest-index set bit of req (bit 7 highest).
REQ-021 last_id register SHALL capture gnt_id at each grant; it is used only by the round-robin option.

Reset
REQ-022 reset=1 at an edge SHALL force:
- state=IDLE
- gnt=0, gnt_id=0, busy=0, expired=0
- hold_cnt=0, last_id=0
REQ-023 Reset during GRANT SHALL drop gnt at that same edge, with no expired pulse.
REQ-024 none SHALL track req even while reset is asserted.

Configuration
REQ-025 Macro ARB8_RR_EN SHALL select the arbitration policy.
- Defined: round-robin. After granting index i, priority order is descending from (i-1) mod 8, wrapping, with i lowest.
- Undefined: fixed priority per REQ-020; last_id is not implemented.
REQ-026 With ARB8_RR_EN defined, last_id=0 after reset, so the first arbitration order (7 highest) equals fixed priority.

Structure
REQ-027 Shared package arb8_pkg SHALL hold:
- the state enum (IDLE, GRANT)
- constant N_REQ=8
- constant ID_W=3
REQ-028 Sub-module prio_enc8 SHALL be used: combinational 8-to-3 highest-index priority encoder with a none flag.
- Round-robin is implemented by rotating req before the encoder and adding the offset back mod 8.

Verification
REQ-029 Reset, then req=8'b0010_0100 -> after next edge gnt=8'b0010_0000, gnt_id=5, busy=1; none=0 throughout.
REQ-030 Fixed priority, owner 5; pulse done for one cycle -> next edge gnt=0; following edge gnt_id=5 again (req unchanged).
REQ-031 ARB8_RR_EN defined, req=8'hFF held, done pulsed each grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7, with one idle cycle between grants.
REQ-032 MAX_HOLD=4, req=8'h01 held, done=0 -> gnt=8'h01 for exactly 4 cycles, then gnt=0 and a one-cycle expired=1 pulse; regrant after one idle cycle.
REQ-033 Owner 3 holding; assert reset for one cycle -> gnt=0, busy=0, expired=0 at that edge; in RR mode, the first grant after reset with req=8'hFF is 7.
REQ-034 req=8'h00 -> none=1, FSM stays in IDLE; done=1 pulses in IDLE cause no change.
